ft2232h_tx_buffer: RTL and testbench

- Byte buffer and burst controller directly upstream of the FT2232H synchronous-FIFO TX stage.
- Accepts bytes from the application on a valid/ready interface and stores them in a circular FIFO.
- Presents bytes to the TX stage in bursts, so the FT2232H sees contiguous WR# strobes instead of isolated single bytes.
- A burst opens on a fill threshold or after an idle timeout, and closes when the buffer is empty.

---
 rtl/ft2232h_pkg.sv | 20 ++
 rtl/ft2232h_byte_fifo.sv | 47 ++++
 rtl/ft2232h_tx_buffer.sv | 123 ++++++++++++
 tb/tb_ft2232h_tx_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft2232h_pkg.sv
// Shared definitions for the FT2232H TX byte buffer.
// Burst state encodings, byte width and a constant clog2 helper.
package ft2232h_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ACCUM = 2'b01;
    localparam logic [1:0] BURST = 2'b10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ft2232h_byte_fifo.sv
// Circular byte FIFO with wrap-bit pointers and first-word-fall-through read.
// Ports: clk, reset (async active-low), push/push_data, pop/pop_data, full, empty, level.
module ft2232h_byte_fifo
    import ft2232h_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0])
                && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign level = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/ft2232h_tx_buffer.sv
// Byte buffer and burst controller feeding the FT2232H sync-FIFO TX stage.
// Ports: clk, reset (async active-low), in_data/in_valid/in_ready,
// out_data/out_valid/out_ready, flush, overflow (sticky).
// Define FT2232H_TX_BUF_LEVEL_EN to add the level and almost_full outputs.
module ft2232h_tx_buffer
    import ft2232h_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int BURST_THRESH = 16,
    parameter int IDLE_TIMEOUT = 255,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic              overflow
`ifdef FT2232H_TX_BUF_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              almost_full
`endif
);

    localparam int LW      = ADDR_W + 1;
    localparam int TIMER_W = clog2(IDLE_TIMEOUT + 1);

    localparam logic [LW-1:0]      THRESH    = LW'(BURST_THRESH);
    localparam logic [LW-1:0]      LVL_ONE   = 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(IDLE_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_ONE = 1;

    logic              full;
    logic              empty;
    logic [LW-1:0]     fill;
    logic [BYTE_W-1:0] head;
    logic              push;
    logic              pop;
    logic              last_pop;
    logic              open_burst;
    logic [1:0]        state;
    logic [TIMER_W-1:0] timer;

    assign push     = in_valid && !full;
    assign pop      = out_valid && out_ready;
    assign last_pop = pop && !push && (fill == LVL_ONE);

    // Pointers are registered, so !full already reflects the post-edge state.
    assign in_ready  = !full;
    assign out_valid = (state == BURST) && !empty;
    assign out_data  = out_valid ? head : '0;

    assign open_burst = flush || (fill >= THRESH) || (timer == TIMER_MAX);

    ft2232h_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (fill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (empty) begin
                        timer <= '0;
                    end else if (flush) begin
                        state <= BURST;
                        timer <= '0;
                    end else begin
                        state <= ACCUM;
                        timer <= TIMER_ONE;
                    end
                end
                ACCUM: begin
                    if (open_burst) begin
                        state <= BURST;
                        timer <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + TIMER_ONE;
                    end
                end
                BURST: begin
                    timer <= '0;
                    if (last_pop || empty) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow <= 1'b0;
        else if (in_valid && full) overflow <= 1'b1;
    end

`ifdef FT2232H_TX_BUF_LEVEL_EN
    localparam logic [LW-1:0] AF_LEVEL = LW'(DEPTH - 4);

    assign level       = fill;
    assign almost_full = (fill >= AF_LEVEL);
`endif

endmodule

// File: tb/tb_ft2232h_tx_buffer.sv
// Self-checking bench for ft2232h_tx_buffer.
// Scoreboard queue filled on accepted pushes, drained on observed pops.
module tb_ft2232h_tx_buffer;
    import ft2232h_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic       overflow;
`ifdef FT2232H_TX_BUF_LEVEL_EN
    logic [6:0] level;
    logic       almost_full;
`endif

    int vectors = 0;
    int errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    ft2232h_tx_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .overflow  (overflow)
`ifdef FT2232H_TX_BUF_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    // Called at a negedge with inputs set; records the handshakes that
    // the coming posedge will perform, then returns at the next negedge.
    task automatic tick(output bit pushed, output bit popped,
                        output logic [7:0] pdata);
        #1;
        pushed = in_valid && in_ready;
        if (pushed) sb.push_back(in_data);
        popped = out_valid && out_ready;
        pdata = out_data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors += 4;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        if (out_data !== 8'h00) begin
            errors++; $display("FAIL rst_out_data: got %h want 00", out_data);
        end
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL rst_overflow: got %b want 0", overflow);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (dut.state !== IDLE) begin
            errors++; $display("FAIL rst_state: got %b want %b", dut.state, IDLE);
        end
    endtask

    task automatic test_threshold();
        bit pu, po;
        logic [7:0] d, e;
        int first = -1;
        int last = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i);
            vectors++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL thr_early_valid: got %b want 0 at push %0d", out_valid, i);
            end
            tick(pu, po, d);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            tick(pu, po, d);
            if (po) begin
                if (first < 0) first = c;
                last = c;
                e = sb.pop_front();
                vectors++;
                if (d !== e) begin
                    errors++; $display("FAIL thr_data: got %h want %h", d, e);
                end
            end
        end
        vectors += 3;
        if (sb.size() != 0) begin
            errors++; $display("FAIL thr_timeout: got %0d left want 0", sb.size());
        end
        if (last - first !== 15) begin
            errors++; $display("FAIL thr_contig: got span %0d want 15", last - first);
        end
        if (dut.state !== IDLE || out_valid !== 1'b0) begin
            errors++; $display("FAIL thr_idle: got state %b valid %b want 00 0", dut.state, out_valid);
        end
    endtask

    task automatic test_timeout();
        bit pu, po;
        logic [7:0] d, e;
        int first = -1;
        int k = 0;
        out_ready = 1'b1;
        while (k < 400 && (k < 3 || sb.size() > 0)) begin
            in_valid = (k < 3);
            in_data = 8'(8'hA0 + k);
            if (out_valid && first < 0) first = k;
            tick(pu, po, d);
            if (po) begin
                e = sb.pop_front();
                vectors++;
                if (d !== e) begin
                    errors++; $display("FAIL to_data: got %h want %h", d, e);
                end
            end
            k++;
        end
        in_valid = 1'b0;
        vectors += 2;
        if (first < 255 || first > 260) begin
            errors++; $display("FAIL to_open: got cycle %0d want 255..260", first);
        end
        if (sb.size() != 0) begin
            errors++; $display("FAIL to_drain: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_flush();
        bit pu, po;
        logic [7:0] d, e;
        out_ready = 1'b1;
        flush = 1'b1;
        tick(pu, po, d);
        flush = 1'b0;
        vectors += 2;
        if (dut.state !== IDLE) begin
            errors++; $display("FAIL fl_empty_state: got %b want %b", dut.state, IDLE);
        end
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL fl_empty_valid: got %b want 0", out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h5A + i);
            tick(pu, po, d);
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL fl_pre_valid: got %b want 0", out_valid);
        end
        flush = 1'b1;
        tick(pu, po, d);
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL fl_open: got %b want 1", out_valid);
        end
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            tick(pu, po, d);
            if (po) begin
                e = sb.pop_front();
                vectors++;
                if (d !== e) begin
                    errors++; $display("FAIL fl_data: got %h want %h", d, e);
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL fl_drain: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_overflow();
        bit pu, po;
        logic [7:0] d, e;
        int pops = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 100 && sb.size() < 64; c++) begin
            in_valid = 1'b1;
            in_data = 8'(c * 7 + 3);
            tick(pu, po, d);
        end
        in_valid = 1'b0;
        vectors += 2;
        if (sb.size() != 64) begin
            errors++; $display("FAIL ov_fill: got %0d want 64", sb.size());
        end
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL ov_in_ready: got %b want 0", in_ready);
        end
        in_valid = 1'b1;
        in_data = 8'hAA;
        tick(pu, po, d);
        in_valid = 1'b0;
        vectors += 2;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ov_set: got %b want 1", overflow);
        end
        if (out_valid !== 1'b1 || out_data !== sb[0]) begin
            errors++; $display("FAIL ov_hold: got %b/%h want 1/%h", out_valid, out_data, sb[0]);
        end
        repeat (5) tick(pu, po, d);
        vectors++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ov_sticky: got %b want 1", overflow);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            tick(pu, po, d);
            if (po) begin
                pops++;
                e = sb.pop_front();
                vectors++;
                if (d !== e) begin
                    errors++; $display("FAIL ov_data: got %h want %h", d, e);
                end
            end
        end
        vectors += 2;
        if (pops != 64) begin
            errors++; $display("FAIL ov_count: got %0d want 64", pops);
        end
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ov_sticky_end: got %b want 1", overflow);
        end
    endtask

    task automatic test_toggle();
        bit pu, po;
        logic [7:0] d, e;
        int pushes = 0;
        int pops = 0;
        for (int c = 0; c < 600 && (pushes < 40 || sb.size() > 0); c++) begin
            out_ready = ((c / 3) % 2) == 0;
            in_valid = (pushes < 40);
            in_data = 8'($urandom);
            flush = (pushes >= 40);
            tick(pu, po, d);
            if (pu) pushes++;
            if (po) begin
                pops++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL tg_extra: got pop %h want none", d);
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if (d !== e) begin
                        errors++; $display("FAIL tg_data: got %h want %h", d, e);
                    end
                end
            end
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (pops != 40 || sb.size() != 0) begin
            errors++; $display("FAIL tg_count: got %0d pops %0d left want 40 0", pops, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        bit pu, po;
        logic [7:0] d;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h30 + i);
            tick(pu, po, d);
        end
        in_valid = 1'b0;
        flush = 1'b1;
        tick(pu, po, d);
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL rm_open: got %b want 1", out_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rm_async: got %b want 0", out_valid);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors += 4;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rm_in_ready: got %b want 1", in_ready);
        end
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL rm_overflow: got %b want 0", overflow);
        end
        if (dut.fill !== 7'd0) begin
            errors++; $display("FAIL rm_level: got %0d want 0", dut.fill);
        end
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rm_valid: got %b want 0", out_valid);
        end
`ifdef FT2232H_TX_BUF_LEVEL_EN
        vectors++;
        if (level !== 7'd0) begin
            errors++; $display("FAIL rm_level_port: got %0d want 0", level);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_timeout();
        test_flush();
        test_overflow();
        test_toggle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
